// File: rtl/qsys_lophilo_ctrl_pkg.sv
// Shared types and constants for the Lophilo multi-channel power controller.
package qsys_lophilo_ctrl_pkg;

  typedef enum logic [2:0] {
    CH_OFF,
    CH_WAIT_SLOT,
    CH_ON,
    CH_FAULT,
    CH_RETRY_WAIT
  } ch_state_e;

  // Avalon-MM word addresses.
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_RSVD     = 2'd3;

  // CTRL byte lanes.
  localparam int LANE_PWR   = 0;
  localparam int LANE_HOE   = 8;
  localparam int LANE_LOE   = 16;
  localparam int LANE_RETRY = 24;

  // STATUS byte lanes.
  localparam int LANE_OC    = 0;
  localparam int LANE_ON    = 8;
  localparam int LANE_FAULT = 16;

endpackage

// File: rtl/qsys_lophilo_ch_fsm.sv
// One power channel: OC synchroniser, debounce, retry timer and channel FSM.
module qsys_lophilo_ch_fsm
  import qsys_lophilo_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int RETRY_CYC    = 65536
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ocn_i,
  input  logic pwr_req_i,
  input  logic hoe_req_i,
  input  logic loe_req_i,
  input  logic auto_retry_i,
  input  logic grant_i,
  output logic waiting_o,
  output logic on_o,
  output logic oc_o,
  output logic fault_set_o,
  output logic pwren_o,
  output logic hoe_o,
  output logic loe_o
);

  localparam int RW = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_CYC - 1);
  localparam logic [7:0]    DB_MAX     = 8'(DEBOUNCE_CYC);

  ch_state_e     state_q, state_d;
  logic          oc_meta_q, oc_sync_q;
  logic [7:0]    db_q, db_d;
  logic [RW-1:0] retry_q, retry_d;

  // State, synchroniser and counters; reset clears all of them.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CH_OFF;
      oc_meta_q <= 1'b0;
      oc_sync_q <= 1'b0;
      db_q      <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      oc_meta_q <= ~ocn_i;
      oc_sync_q <= oc_meta_q;
      db_q      <= db_d;
      retry_q   <= retry_d;
    end
  end

  // Saturating debounce counter: counts while OC is high, clears when low.
  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    db_d = '0;
    if (oc_sync_q) db_d = (db_q == DB_MAX) ? db_q : db_q + 8'd1;
  end

  assign oc_o = (db_q == DB_MAX);

  // Next state; a dropped power request always wins, including over a grant.
  always_comb begin
    state_d     = state_q;
    fault_set_o = 1'b0;
    unique case (state_q)
      CH_OFF:       if (pwr_req_i) state_d = CH_WAIT_SLOT;
      CH_WAIT_SLOT: begin
        if (!pwr_req_i)   state_d = CH_OFF;
        else if (grant_i) state_d = CH_ON;
      end
      CH_ON: begin
        if (!pwr_req_i) state_d = CH_OFF;
        else if (oc_o) begin
          state_d     = CH_FAULT;
          fault_set_o = 1'b1;
        end
      end
      CH_FAULT: begin
        if (!pwr_req_i)        state_d = CH_OFF;
        else if (auto_retry_i) state_d = CH_RETRY_WAIT;
      end
      CH_RETRY_WAIT: begin
        if (!pwr_req_i)                state_d = CH_OFF;
        else if (retry_q == RETRY_LAST) state_d = CH_WAIT_SLOT;
      end
      default: state_d = CH_OFF;
    endcase
    retry_d = '0;
    if (state_q == CH_RETRY_WAIT && state_d == CH_RETRY_WAIT) retry_d = retry_q + RW'(1);
  end

  // Outputs decode the registered state, so PWREN rises the cycle ON is left.
  assign waiting_o = (state_q == CH_WAIT_SLOT);
  assign on_o      = (state_q == CH_ON);
  assign pwren_o   = ~on_o;
  assign hoe_o     = on_o & hoe_req_i;
  assign loe_o     = on_o & loe_req_i;

endmodule

// File: rtl/qsys_lophilo_multi_module_ctrl.sv
// N-channel module power controller: Avalon-MM registers, staggered power-up
// sequencer, per-channel FSMs and a maskable over-current IRQ.
module qsys_lophilo_multi_module_ctrl
  import qsys_lophilo_ctrl_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int RETRY_CYC    = 65536,
  parameter int PWRUP_GAP    = 256
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset,
  input  logic [1:0]        avs_Ctrl_address,
  input  logic [31:0]       avs_Ctrl_writedata,
  output logic [31:0]       avs_Ctrl_readdata,
  input  logic [3:0]        avs_Ctrl_byteenable,
  input  logic              avs_Ctrl_write,
  input  logic              avs_Ctrl_read,
  output logic              avs_Ctrl_waitrequest,
  output logic              ins_OC_irq,
  input  logic [NUM_CH-1:0] coe_OCN,
  output logic [NUM_CH-1:0] coe_PWREN,
  output logic [NUM_CH-1:0] coe_HOE,
  output logic [NUM_CH-1:0] coe_LOE
);

  localparam logic [7:0] CH_MASK = 8'((1 << NUM_CH) - 1);

  logic [31:0]       ctrl_q, ctrl_d;
  logic [7:0]        sticky_q, sticky_d, mask_q, mask_d, clr;
  logic [15:0]       gap_q, gap_d;
  logic              irq_q, found;
  logic [NUM_CH-1:0] wait_w, on_w, oc_w, fset_w, grant_w;
  logic              unused_read;

  // Reads are purely address-decoded; the strobe carries no information here.
  assign unused_read          = avs_Ctrl_read;
  assign avs_Ctrl_waitrequest = 1'b0;
  assign ins_OC_irq           = irq_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    qsys_lophilo_ch_fsm #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .RETRY_CYC   (RETRY_CYC)
    ) u_ch (
      .clk_i       (csi_MCLK_clk),
      .rst_i       (rsi_MRST_reset),
      .ocn_i       (coe_OCN[i]),
      .pwr_req_i   (ctrl_q[LANE_PWR + i]),
      .hoe_req_i   (ctrl_q[LANE_HOE + i]),
      .loe_req_i   (ctrl_q[LANE_LOE + i]),
      .auto_retry_i(ctrl_q[LANE_RETRY + i]),
      .grant_i     (grant_w[i]),
      .waiting_o   (wait_w[i]),
      .on_o        (on_w[i]),
      .oc_o        (oc_w[i]),
      .fault_set_o (fset_w[i]),
      .pwren_o     (coe_PWREN[i]),
      .hoe_o       (coe_HOE[i]),
      .loe_o       (coe_LOE[i])
    );
  end

  // Sequencer: lowest waiting channel wins once the inrush gap has expired.
  always_comb begin
    grant_w = '0;
    found   = 1'b0;
    if (gap_q == '0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wait_w[i] && !found) begin
          grant_w[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    gap_d = gap_q;
    if (|grant_w)          gap_d = 16'(PWRUP_GAP - 1);
    else if (gap_q != '0)  gap_d = gap_q - 16'd1;
  end

  // Register writes; a fault entry beats a same-cycle W1C of its sticky bit.
  always_comb begin
    ctrl_d = ctrl_q;
    mask_d = mask_q;
    clr    = '0;
    if (avs_Ctrl_write) begin
      unique case (avs_Ctrl_address)
        ADDR_CTRL: begin
          for (int b = 0; b < 4; b++) begin
            if (avs_Ctrl_byteenable[b]) ctrl_d[8*b +: 8] = avs_Ctrl_writedata[8*b +: 8] & CH_MASK;
          end
        end
        ADDR_STATUS:   if (avs_Ctrl_byteenable[2]) clr = avs_Ctrl_writedata[LANE_FAULT +: 8] & CH_MASK;
        ADDR_IRQ_MASK: if (avs_Ctrl_byteenable[0]) mask_d = avs_Ctrl_writedata[7:0] & CH_MASK;
        default: ;
      endcase
    end
    sticky_d = (sticky_q & ~clr) | 8'(fset_w);
  end

  // Read mux.
  always_comb begin
    avs_Ctrl_readdata = '0;
    unique case (avs_Ctrl_address)
      ADDR_CTRL:     avs_Ctrl_readdata = ctrl_q;
      ADDR_STATUS:   avs_Ctrl_readdata = {8'h00, sticky_q, 8'(on_w), 8'(oc_w)};
      ADDR_IRQ_MASK: avs_Ctrl_readdata = {24'h0, mask_q};
      ADDR_RSVD:     avs_Ctrl_readdata = '0;
      default:       avs_Ctrl_readdata = '0;
    endcase
  end

  // Register file, gap counter and IRQ flop.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      ctrl_q   <= '0;
      sticky_q <= '0;
      mask_q   <= '0;
      gap_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      sticky_q <= sticky_d;
      mask_q   <= mask_d;
      gap_q    <= gap_d;
      irq_q    <= |(sticky_q & mask_q);
    end
  end

endmodule

// File: tb/tb_qsys_lophilo_multi_module_ctrl.sv
// Self-checking bench for the Lophilo multi-channel power controller.
module tb_qsys_lophilo_multi_module_ctrl;

  localparam int NUM_CH = 4;
  localparam int DEB    = 16;
  localparam int RETRY  = 1000;
  localparam int GAP    = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        address = '0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [3:0]        byteenable = '0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic              waitrequest;
  logic              irq;
  logic [NUM_CH-1:0] ocn = '1;
  logic [NUM_CH-1:0] pwren, hoe, loe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qsys_lophilo_multi_module_ctrl #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CYC(DEB), .RETRY_CYC(RETRY), .PWRUP_GAP(GAP)
  ) dut (
    .csi_MCLK_clk        (clk),
    .rsi_MRST_reset      (rst),
    .avs_Ctrl_address    (address),
    .avs_Ctrl_writedata  (writedata),
    .avs_Ctrl_readdata   (readdata),
    .avs_Ctrl_byteenable (byteenable),
    .avs_Ctrl_write      (write),
    .avs_Ctrl_read       (read),
    .avs_Ctrl_waitrequest(waitrequest),
    .ins_OC_irq          (irq),
    .coe_OCN             (ocn),
    .coe_PWREN           (pwren),
    .coe_HOE             (hoe),
    .coe_LOE             (loe)
  );

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    #1;
    d    = readdata;
    read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    tick();
    write      = 1'b0;
    byteenable = '0;
  endtask

  // Returns the number of cycles until pwren[c] reaches val, or -1 on timeout.
  task automatic wait_pwren(input int c, input logic val, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (pwren[c] === val) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] m_ctrl;
    logic [7:0]  m_sticky, m_mask;
    logic [1:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    int          n;
    int          on_t[NUM_CH];
    logic        found;

    vecs[0]  = '{2'd0, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000};
    vecs[1]  = '{2'd1, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000};
    vecs[2]  = '{2'd2, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000};
    vecs[3]  = '{2'd3, 32'h0000_0000, 4'h0, 1'b0, 32'h0000_0000};
    vecs[4]  = '{2'd2, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_000F};
    vecs[5]  = '{2'd2, 32'h0000_00A5, 4'hE, 1'b1, 32'h0000_000F};
    vecs[6]  = '{2'd2, 32'h0000_0002, 4'h1, 1'b1, 32'h0000_0002};
    vecs[7]  = '{2'd3, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0000};
    vecs[8]  = '{2'd0, 32'h0F0E_0D00, 4'h6, 1'b1, 32'h000E_0D00};
    vecs[9]  = '{2'd0, 32'hFFFF_FFFF, 4'h8, 1'b1, 32'h0F0E_0D00};
    vecs[10] = '{2'd1, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0000_0000};
    vecs[11] = '{2'd0, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};

    repeat (3) tick();
    rst = 1'b0;

    // Reset state and register-file vectors; nothing is powered throughout.
    check("reset irq", {31'h0, irq}, 32'h0);
    check("reset waitrequest", {31'h0, waitrequest}, 32'h0);
    foreach (vecs[i]) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      rd(vecs[i].addr, r);
      check($sformatf("vec%0d read", i), r, vecs[i].exp);
      check($sformatf("vec%0d outs", i), {20'h0, pwren, hoe, loe}, 32'h0000_0F00);
    end

    // Staggered power-up of all channels.
    do_write(2'd0, 32'h000A_0F0F, 4'hF);
    foreach (on_t[c]) on_t[c] = -1;
    for (int k = 1; k <= 1200; k++) begin
      tick();
      for (int c = 0; c < NUM_CH; c++) if (on_t[c] < 0 && pwren[c] === 1'b0) on_t[c] = k;
      if (pwren === '0) break;
    end
    check("first grant latency", on_t[0], 2);
    for (int c = 1; c < NUM_CH; c++) check($sformatf("gap ch%0d", c), on_t[c] - on_t[c-1], GAP);
    rd(2'd1, r);
    check("status all on", r, 32'h0000_0F00);
    check("hoe all on", {28'h0, hoe}, 32'hF);
    check("loe all on", {28'h0, loe}, 32'hA);

    // OC one cycle short of the debounce threshold: no fault.
    ocn[1] = 1'b0;
    repeat (DEB - 1) tick();
    ocn[1] = 1'b1;
    repeat (5) tick();
    check("short oc pwren", {28'h0, pwren}, 32'h0);
    rd(2'd1, r);
    check("short oc status", r, 32'h0000_0F00);

    // OC held: fault after threshold plus synchroniser and state latency.
    ocn[1] = 1'b0;
    wait_pwren(1, 1'b1, 40, n);
    check("fault latency", n, DEB + 3);
    check("fault hoe", {28'h0, hoe}, 32'hD);
    check("fault loe", {28'h0, loe}, 32'h8);
    rd(2'd1, r);
    check("fault status", r, 32'h0002_0D02);
    check("irq before latency", {31'h0, irq}, 32'h0);
    tick();
    check("irq after latency", {31'h0, irq}, 32'h1);
    ocn[1] = 1'b1;
    repeat (2) tick();
    rd(2'd1, r);
    check("debounced oc still high", {24'h0, r[7:0]}, 32'h02);
    tick();
    rd(2'd1, r);
    check("debounced oc dropped", {24'h0, r[7:0]}, 32'h00);

    // Randomised register traffic against a register-level model (ch1 parked in FAULT).
    m_ctrl = 32'h000A_0F0F;
    m_sticky = 8'h02;
    m_mask = 8'h02;
    for (int k = 0; k < 40; k++) begin
      a  = 2'($urandom_range(0, 3));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      if (a == 2'd0) begin
        d[7:0] = 8'h0F;
        d[25]  = 1'b0;
        for (int b = 0; b < 4; b++) if (be[b]) m_ctrl[8*b +: 8] = d[8*b +: 8] & 8'h0F;
      end
      if (a == 2'd1 && be[2]) m_sticky = m_sticky & ~(d[23:16] & 8'h0F);
      if (a == 2'd2 && be[0]) m_mask = d[7:0] & 8'h0F;
      do_write(a, d, be);
      rd(2'd0, r);
      check("rand ctrl", r, m_ctrl);
      rd(2'd1, r);
      check("rand status", r, {8'h00, m_sticky, 8'h0D, 8'h00});
      rd(2'd2, r);
      check("rand mask", r, {24'h0, m_mask});
      check("rand hoe", {28'h0, hoe}, {28'h0, m_ctrl[11:8] & 4'hD});
      check("rand loe", {28'h0, loe}, {28'h0, m_ctrl[19:16] & 4'hD});
      check("rand pwren", {28'h0, pwren}, 32'h2);
      tick();
      check("rand irq", {31'h0, irq}, {31'h0, |(m_sticky & m_mask)});
    end

    // Auto-retry: RETRY_CYC cycles in RETRY_WAIT, then an immediate re-grant.
    do_write(2'd2, 32'h0000_0002, 4'h1);
    do_write(2'd0, 32'h020A_0F0F, 4'hF);
    wait_pwren(1, 1'b0, 1100, n);
    check("retry re-grant", n, RETRY + 2);

    // Clear without a fault.
    do_write(2'd1, 32'h0002_0000, 4'b0100);
    rd(2'd1, r);
    check("w1c clears sticky", {24'h0, r[23:16]}, 32'h0);
    tick();
    check("irq after clear", {31'h0, irq}, 32'h0);

    // W1C landing on the very edge of a new fault: the set wins.
    ocn[1] = 1'b0;
    repeat (DEB + 2) tick();
    do_write(2'd1, 32'h0002_0000, 4'b0100);
    check("same-edge fault pwren", {31'h0, pwren[1]}, 32'h1);
    rd(2'd1, r);
    check("set beats clear", {24'h0, r[23:16]}, 32'h02);
    tick();
    check("irq after set", {31'h0, irq}, 32'h1);

    // Clear during RETRY_WAIT, then OC still asserted faults again after retry.
    repeat (3) tick();
    do_write(2'd1, 32'h0002_0000, 4'b0100);
    rd(2'd1, r);
    check("clear in retry", {24'h0, r[23:16]}, 32'h0);
    tick();
    check("irq after retry clear", {31'h0, irq}, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 1100 && !found; k++) begin
      tick();
      rd(2'd1, r);
      if (r[17]) found = 1'b1;
    end
    check("refault sets sticky", {31'h0, found}, 32'h1);
    check("refault pwren", {31'h0, pwren[1]}, 32'h1);
    ocn[1] = 1'b1;
    repeat (2) tick();

    // Restart ch3 while the gap from ch1's re-grant is still running.
    do_write(2'd0, 32'h0000_0007, 4'h1);
    tick();
    do_write(2'd0, 32'h0000_000F, 4'h1);
    repeat (5) tick();
    check("ch3 held by gap", {31'h0, pwren[3]}, 32'h1);
    check("irq before reset", {31'h0, irq}, 32'h1);

    // Reset mid-retry and mid-gap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset pwren", {28'h0, pwren}, 32'hF);
    check("reset hoe/loe", {24'h0, hoe, loe}, 32'h0);
    check("reset irq again", {31'h0, irq}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      rd(2'(k), r);
      check($sformatf("reset addr%0d", k), r, 32'h0);
    end
    do_write(2'd0, 32'h0000_000F, 4'hF);
    wait_pwren(0, 1'b0, 10, n);
    check("grant after reset", n, 2);
    wait_pwren(1, 1'b0, 300, n);
    check("gap after reset", n, GAP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qsys_lophilo_multi_module_ctrl.md
Name: qsys_lophilo_multi_module_ctrl

Overview:
- Parametrised N-channel successor to the two-port Lophilo module power/level-shifter controller, sitting as an Avalon-MM slave in the Qsys root.
- Each channel has its own FSM: debounced over-current detection, immediate latch-off, sticky fault status and optional auto-retry.
- Power-up is staggered across channels to limit inrush.
- A maskable over-current IRQ goes to the MCU.

Parameters:
- NUM_CH, 4, channel count, 1..8.
- DEBOUNCE_CYC, 16, consecutive cycles of asserted OC before a fault is declared, 1..255.
- RETRY_CYC, 65536, cycles spent in RETRY_WAIT before re-power, 1..2^20.
- PWRUP_GAP, 256, minimum cycles between successive channel power-on grants, 1..65535.

Ports:
- csi_MCLK_clk  in  1  system clock.
- rsi_MRST_reset  in  1  reset; synchronous, active-high.
- avs_Ctrl_address  in  2  word address.
- avs_Ctrl_writedata  in  32  write data.
- avs_Ctrl_readdata  out  32  read data, combinational from address.
- avs_Ctrl_byteenable  in  4  byte enables.
- avs_Ctrl_write  in  1  write strobe.
- avs_Ctrl_read  in  1  read strobe.
- avs_Ctrl_waitrequest  out  1  tied 0.
- ins_OC_irq  out  1  registered OR of (sticky fault & mask).
- coe_OCN  in  NUM_CH  per-channel over-current, active-low, asynchronous.
- coe_PWREN  out  NUM_CH  per-channel power switch, active-low (1 = off).
- coe_HOE  out  NUM_CH  high-side level-shifter output enable.
- coe_LOE  out  NUM_CH  low-side level-shifter output enable.

Behaviour:
- Register map. Bit i is channel i; bits at or above NUM_CH in each byte read 0 and ignore writes.
- addr0 CTRL (RW): [7:0] PWR_REQ, [15:8] HOE_REQ, [23:16] LOE_REQ, [31:24] AUTO_RETRY. Byte-enable honoured per byte.
- addr1 STATUS: [7:0] debounced OC (RO), [15:8] channel ON (RO), [23:16] sticky FAULT (W1C when byteenable[2] is set).
- addr2 IRQ_MASK (RW): [7:0].
- addr3: reads 0, writes ignored.
- Reset: all registers 0, every FSM in OFF, coe_PWREN all 1, coe_HOE/coe_LOE all 0, ins_OC_irq 0, all counters 0.
- OC path: 2-flop synchroniser on ~coe_OCN, then a per-channel saturating counter.
  - Counter increments while OC is high and clears to 0 while OC is low.
  - Debounced OC = counter reaches DEBOUNCE_CYC; it deasserts the cycle after the synchronised OC drops.
- Channel FSM, per channel:
  - OFF: PWREN=1. PWR_REQ=1 -> WAIT_SLOT.
  - WAIT_SLOT: PWR_REQ=0 -> OFF. Sequencer grant -> ON.
  - ON: PWREN=0; HOE = HOE_REQ; LOE = LOE_REQ.
    - PWR_REQ=0 -> OFF.
    - Debounced OC -> FAULT. PWREN returns to 1 the cycle the FSM leaves ON, so outputs are registered from state.
  - FAULT: PWREN=1; sticky bit set on entry.
    - PWR_REQ=0 -> OFF.
    - Otherwise AUTO_RETRY=1 -> RETRY_WAIT.
    - Otherwise stay in FAULT.
  - RETRY_WAIT: PWR_REQ=0 -> OFF. After RETRY_CYC cycles -> WAIT_SLOT.
  - HOE and LOE are 0 in every state except ON.
- Sequencer:
  - Grants the lowest-index channel in WAIT_SLOT, one grant per cycle maximum.
  - After a grant, no further grant until PWRUP_GAP cycles have elapsed. The gap counter starts at 0 from reset, so the first grant is immediate.
- Simultaneous events:
  - Fault entry and a W1C clear of the same bit in one cycle: set wins.
  - PWR_REQ cleared in the same cycle as a grant: channel goes to OFF.
- IRQ: ins_OC_irq <= |(FAULT_sticky & IRQ_MASK), one cycle of latency.
- A reset asserted mid-operation returns everything to reset values on the next edge, including mid-retry and mid-gap counters.

Decomposition:
- Package qsys_lophilo_ctrl_pkg: channel-state enum (OFF, WAIT_SLOT, ON, FAULT, RETRY_WAIT), register address constants, byte-lane field offsets.
- One sub-module qsys_lophilo_ch_fsm, instantiated NUM_CH times: synchroniser, debounce counter, retry counter, FSM.
- The sequencer, register file and IRQ logic stay in the top module.

Test Plan:
- Reset, then read addr0..3 -> all 0; coe_PWREN=4'hF; HOE/LOE=0; irq=0.
- PWRUP_GAP=256; write CTRL PWR_REQ=4'hF -> ch0 PWREN low on grant; ch1 exactly 256 cycles later; ch2 and ch3 each a further 256; STATUS[15:8]=4'hF.
- Ch1 ON, coe_OCN[1] low for 15 cycles -> no fault. Low for 16+2 sync cycles -> PWREN[1]=1, HOE[1]=LOE[1]=0, STATUS[23:16]=8'h02. With IRQ_MASK=2, irq=1 one cycle after the sticky bit sets.
- AUTO_RETRY[1]=1, RETRY_CYC=1000, OC released -> ch1 re-enters WAIT_SLOT after 1000 cycles and is re-granted. If OC is still asserted, it faults again and the sticky bit stays set.
- W1C 0x00020000 to addr1 with byteenable=4'b0100 in the same cycle as a new ch1 fault -> sticky stays 1. A later clear without a fault -> sticky 0, irq 0.
- Reset asserted during RETRY_WAIT and during the sequencer gap -> next cycle all channels OFF and registers 0. The first grant after reset is immediate.
